// File: rtl/thread_sched_pkg.sv
// Shared types for the barrel thread scheduler: per-thread state encoding
// and the shortest select delay line the core pipeline can use.
package thread_sched_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        READY = 2'b01,
        WAIT  = 2'b10
    } thread_state_e;

    localparam int MIN_PIPE_DEPTH = 3;

endpackage

// File: rtl/thread_sched_rr_arbiter.sv
// One-hot rotating-priority arbiter: the request just after the last grant
// wins; no requests gives an all-zero grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] last_i,
    output logic [N-1:0] grant_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    int            last_idx;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o  = '0;
        last_idx = N - 1;
        idx      = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (last_i[i]) last_idx = i;
        end
        // Walk the ring starting one past the previous winner.
        for (int off = 1; off <= N; off++) begin
            idx = IW'((last_idx + off) % N);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_sched.sv
// Barrel thread scheduler: per-thread OFF/READY/WAIT tracking, round-robin
// fetch select and a select delay line to WB. THREAD_SCHED_PERF_EN builds issue counters.
module thread_sched
    import thread_sched_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int PIPE_DEPTH  = 5,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_THREADS-1:0]           thread_en,
    input  logic                             stall,
    input  logic                             wait_set,
    input  logic [NUM_THREADS-1:0]           wait_thread,
    input  logic [NUM_THREADS-1:0]           wait_done,
    output logic [NUM_THREADS-1:0]           thread_sel_IF,
    output logic [NUM_THREADS-1:0]           thread_sel_ID,
    output logic [NUM_THREADS-1:0]           thread_sel_WB,
    output logic                             issue_valid,
    output logic [2*NUM_THREADS-1:0]         thread_state,
    output logic [NUM_THREADS*CNT_WIDTH-1:0] issue_cnt
);

    if (PIPE_DEPTH < MIN_PIPE_DEPTH) begin : g_depth_chk
        $error("thread_sched: PIPE_DEPTH below minimum");
    end

    localparam logic [NUM_THREADS-1:0] LAST_RST = NUM_THREADS'(1) << (NUM_THREADS - 1);

    thread_state_e          state_q [NUM_THREADS];
    thread_state_e          state_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] park;
    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] grant;
    logic [NUM_THREADS-1:0] last_q;
    logic [NUM_THREADS-1:0] sel_pipe_q [PIPE_DEPTH];

    // A thread parked this edge must not also be chosen for fetch.
    always_comb begin
        park     = '0;
        eligible = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            park[i]     = wait_set && wait_thread[i] && !stall && (state_q[i] == READY);
            eligible[i] = thread_en[i] && (state_q[i] == READY) && !park[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            state_d[i] = state_q[i];
            if (!thread_en[i]) begin
                state_d[i] = OFF;
            end else begin
                case (state_q[i])
                    OFF:     state_d[i] = READY;
                    READY:   if (park[i]) state_d[i] = WAIT;
                    WAIT:    if (wait_done[i]) state_d[i] = READY;
                    default: state_d[i] = OFF;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) state_q[i] <= OFF;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) state_q[i] <= state_d[i];
        end
    end

    rr_arbiter #(
        .N(NUM_THREADS)
    ) u_arb (
        .req_i  (eligible),
        .last_i (last_q),
        .grant_o(grant)
    );

    // Bubbles leave the rotation pointer alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= LAST_RST;
            for (int k = 0; k < PIPE_DEPTH; k++) sel_pipe_q[k] <= '0;
        end else if (!stall) begin
            if (|grant) last_q <= grant;
            sel_pipe_q[0] <= grant;
            for (int k = 1; k < PIPE_DEPTH; k++) sel_pipe_q[k] <= sel_pipe_q[k-1];
        end
    end

    assign thread_sel_IF = sel_pipe_q[0];
    assign thread_sel_ID = sel_pipe_q[1];
    assign thread_sel_WB = sel_pipe_q[PIPE_DEPTH-1];
    assign issue_valid   = |sel_pipe_q[0];

    always_comb begin
        thread_state = '0;
        for (int i = 0; i < NUM_THREADS; i++) thread_state[2*i +: 2] = state_q[i];
    end

`ifdef THREAD_SCHED_PERF_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_THREADS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) cnt_q[i] <= '0;
        end else if (!stall) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (grant[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < NUM_THREADS; i++) issue_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
`else
    assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_thread_sched.sv
// Scoreboard bench for thread_sched: stimulus queues edge-tagged expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_thread_sched;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   thread_en = '0;
    logic         stall = 1'b0;
    logic         wait_set = 1'b0;
    logic [3:0]   wait_thread = '0;
    logic [3:0]   wait_done = '0;
    logic [3:0]   thread_sel_IF;
    logic [3:0]   thread_sel_ID;
    logic [3:0]   thread_sel_WB;
    logic         issue_valid;
    logic [7:0]   thread_state;
    logic [127:0] issue_cnt;

    thread_sched #(
        .NUM_THREADS(4),
        .PIPE_DEPTH (5),
        .CNT_WIDTH  (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .thread_en    (thread_en),
        .stall        (stall),
        .wait_set     (wait_set),
        .wait_thread  (wait_thread),
        .wait_done    (wait_done),
        .thread_sel_IF(thread_sel_IF),
        .thread_sel_ID(thread_sel_ID),
        .thread_sel_WB(thread_sel_WB),
        .issue_valid  (issue_valid),
        .thread_state (thread_state),
        .issue_cnt    (issue_cnt)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    localparam int K_IF = 0, K_ID = 1, K_WB = 2, K_VLD = 3, K_ST = 4, K_CNT = 5;

    typedef struct {
        int           cyc;
        int           kind;
        logic [127:0] val;
        string        nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void expect_at(int c, int kind, logic [127:0] v, string nm);
        exp_t e;
        e.cyc = c; e.kind = kind; e.val = v; e.nm = nm;
        sb.push_back(e);
    endfunction

    function automatic logic [127:0] cnt4(int c3, int c2, int c1, int c0);
`ifdef THREAD_SCHED_PERF_EN
        return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
`else
        return '0;
`endif
    endfunction

    function automatic logic [127:0] actual(int kind);
        case (kind)
            K_IF:    return 128'(thread_sel_IF);
            K_ID:    return 128'(thread_sel_ID);
            K_WB:    return 128'(thread_sel_WB);
            K_VLD:   return 128'(issue_valid);
            K_ST:    return 128'(thread_state);
            default: return issue_cnt;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= edge_cnt) begin
                total++;
                if (sb[i].cyc < edge_cnt) begin
                    bad++;
                    $display("FAIL %s: expectation for edge %0d never checked (now %0d)",
                             sb[i].nm, sb[i].cyc, edge_cnt);
                end else if (actual(sb[i].kind) !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s @edge %0d: got %0h expected %0h",
                             sb[i].nm, sb[i].cyc, actual(sb[i].kind), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic nxt(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        thread_en = '0; stall = 1'b0; wait_set = 1'b0; wait_thread = '0; wait_done = '0;
        expect_at(edge_cnt + 1, K_IF,  0, "rst_if");
        expect_at(edge_cnt + 1, K_WB,  0, "rst_wb");
        expect_at(edge_cnt + 1, K_VLD, 0, "rst_vld");
        expect_at(edge_cnt + 1, K_ST,  0, "rst_state");
        expect_at(edge_cnt + 1, K_CNT, 0, "rst_cnt");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int E;
    int R;
    int t2_if [10] = '{1, 2, 4, 8, 1, 4, 8, 1, 2, 4};
    int t4_if [11] = '{1, 2, 4, 8, 8, 0, 0, 0, 0, 4, 4};

    initial begin
        // Single thread pair: 0 and 2 alternate.
        do_reset();
        E = edge_cnt;
        thread_en = 4'b0101;
        expect_at(E + 1, K_IF, 0, "t1_if_idle");
        expect_at(E + 1, K_ST, 8'h11, "t1_state");
        for (int k = 0; k < 6; k++)
            expect_at(E + 2 + k, K_IF, (k % 2) ? 4'b0100 : 4'b0001, "t1_if");
        expect_at(E + 2, K_VLD, 1, "t1_vld");
        expect_at(E + 3, K_ID, 4'b0001, "t1_id");
        expect_at(E + 5, K_WB, 0, "t1_wb_empty");
        expect_at(E + 6, K_WB, 4'b0001, "t1_wb0");
        expect_at(E + 7, K_WB, 4'b0100, "t1_wb1");
        expect_at(E + 7, K_CNT, cnt4(0, 3, 0, 3), "t1_cnt");
        nxt(8);

        // Park thread 1 from ID, then wake it.
        do_reset();
        E = edge_cnt;
        thread_en = 4'b1111;
        for (int k = 0; k < 10; k++) expect_at(E + 2 + k, K_IF, t2_if[k], "t2_if");
        expect_at(E + 4, K_ID, 4'b0010, "t2_id_t1");
        expect_at(E + 5, K_ST, 8'h59, "t2_state_park");
        expect_at(E + 7, K_ST, 8'h59, "t2_state_wait");
        expect_at(E + 8, K_ST, 8'h55, "t2_state_wake");
        expect_at(E + 11, K_CNT, cnt4(2, 3, 2, 3), "t2_cnt");
        nxt(4);
        wait_set = 1'b1; wait_thread = 4'b0010;
        nxt(1);
        wait_set = 1'b0; wait_thread = '0;
        nxt(2);
        wait_done = 4'b0010;
        nxt(1);
        wait_done = '0;
        nxt(4);

        // Three-cycle stall.
        do_reset();
        E = edge_cnt;
        thread_en = 4'b1111;
        for (int k = 4; k < 8; k++) expect_at(E + k, K_IF, 4'b0100, "t3_if_hold");
        for (int k = 5; k < 8; k++) begin
            expect_at(E + k, K_ID, 4'b0010, "t3_id_hold");
            expect_at(E + k, K_WB, 0, "t3_wb_hold");
        end
        expect_at(E + 6, K_VLD, 1, "t3_vld");
        expect_at(E + 4, K_CNT, cnt4(0, 1, 1, 1), "t3_cnt_pre");
        expect_at(E + 7, K_CNT, cnt4(0, 1, 1, 1), "t3_cnt_hold");
        expect_at(E + 8, K_CNT, cnt4(1, 1, 1, 1), "t3_cnt_post");
        expect_at(E + 8, K_IF, 4'b1000, "t3_if_resume");
        expect_at(E + 8, K_ID, 4'b0100, "t3_id_resume");
        expect_at(E + 9, K_IF, 4'b0001, "t3_if_next");
        expect_at(E + 9, K_WB, 4'b0001, "t3_wb0");
        expect_at(E + 10, K_WB, 4'b0010, "t3_wb1");
        nxt(4);
        stall = 1'b1;
        nxt(3);
        stall = 1'b0;
        nxt(4);

        // Park every thread, wake thread 2, then disable thread 0 while waiting.
        do_reset();
        E = edge_cnt;
        thread_en = 4'b1111;
        for (int k = 0; k < 11; k++) expect_at(E + 2 + k, K_IF, t4_if[k], "t4_if");
        for (int k = 7; k < 11; k++) expect_at(E + k, K_VLD, 0, "t4_vld_bubble");
        expect_at(E + 11, K_VLD, 1, "t4_vld_resume");
        expect_at(E + 7, K_ST, 8'hAA, "t4_state_allwait");
        expect_at(E + 10, K_ST, 8'h9A, "t4_state_wake2");
        expect_at(E + 10, K_CNT, cnt4(2, 1, 1, 1), "t4_cnt");
        for (int k = 13; k < 18; k++) expect_at(E + k, K_IF, 4'b0100, "t5_if_only2");
        expect_at(E + 13, K_ST, 8'h98, "t5_state_off");
        expect_at(E + 14, K_ST, 8'h98, "t5_state_stay_off");
        expect_at(E + 17, K_CNT, cnt4(2, 8, 1, 1), "t5_cnt");
        nxt(3);
        wait_set = 1'b1; wait_thread = 4'b0001;
        nxt(1);
        wait_thread = 4'b0010;
        nxt(1);
        wait_thread = 4'b0100;
        nxt(1);
        wait_thread = 4'b1000;
        nxt(1);
        wait_set = 1'b0; wait_thread = '0;
        nxt(2);
        wait_done = 4'b0100;
        nxt(1);
        wait_done = '0;
        nxt(2);
        thread_en = 4'b1110;
        nxt(1);
        wait_done = 4'b0001;
        nxt(1);
        wait_done = '0;
        nxt(3);

        // 100 issues, then asynchronous reset between clock edges.
        do_reset();
        E = edge_cnt;
        thread_en = 4'b1111;
        expect_at(E + 101, K_CNT, cnt4(25, 25, 25, 25), "t6_cnt100");
        expect_at(E + 101, K_IF, 4'b1000, "t6_if100");
        expect_at(E + 101, K_ST, 8'h55, "t6_state");
        nxt(101);
        @(posedge clk);
        #2;
        reset = 1'b1;
        R = edge_cnt;
        expect_at(R, K_IF,  0, "t6_arst_if");
        expect_at(R, K_ID,  0, "t6_arst_id");
        expect_at(R, K_WB,  0, "t6_arst_wb");
        expect_at(R, K_VLD, 0, "t6_arst_vld");
        expect_at(R, K_ST,  0, "t6_arst_state");
        expect_at(R, K_CNT, 0, "t6_arst_cnt");
        nxt(2);
        reset = 1'b0;
        nxt(2);

        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL %s: expectation for edge %0d left unchecked", sb[i].nm, sb[i].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thread_sched.md
# thread_sched

Fine-grained (barrel) thread scheduler for the 4-thread RISC-V core. Each cycle it selects one READY hardware thread for fetch using rotating round-robin priority. It tracks per-thread OFF/READY/WAIT state for long-latency operations such as memory and accelerator calls. It also carries the one-hot thread select down a pipeline delay line so that ID-stage reads and WB-stage writes of the per-thread register files use the matching thread.

## Interface
- NUM_THREADS, 4: thread count; width of every one-hot select.
- PIPE_DEPTH, 5: number of select-delay stages from IF to WB; minimum 3.
- CNT_WIDTH, 32: width of each per-thread issue counter.
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- thread_en  in  NUM_THREADS  per-thread run enable (level).
- stall  in  1  global pipeline stall; freezes issue and the delay line.
- wait_set  in  1  the instruction in ID is long-latency; park its thread.
- wait_thread  in  NUM_THREADS  one-hot thread to park; qualified by wait_set.
- wait_done  in  NUM_THREADS  per-thread completion pulses.
- thread_sel_IF  out  NUM_THREADS  one-hot thread fetched this cycle; 0 = bubble.
- thread_sel_ID  out  NUM_THREADS  delay-line stage 1.
- thread_sel_WB  out  NUM_THREADS  delay-line stage PIPE_DEPTH-1.
- issue_valid  out  1  thread_sel_IF is non-zero.
- thread_state  out  2*NUM_THREADS  per-thread state; thread i occupies bits [2i+1:2i].
- issue_cnt  out  NUM_THREADS*CNT_WIDTH  per-thread issue counters; thread i occupies slice i.

## Operation
- State encoding: OFF=2'b00, READY=2'b01, WAIT=2'b10.
- Transition priority, per thread, applied on every edge:
  - thread_en low: next state is OFF, regardless of current state.
  - OFF with thread_en high: next state is READY.
  - READY with wait_set and its wait_thread bit set and stall low: next state is WAIT.
  - WAIT with its wait_done bit set: next state is READY.
  - wait_done on a thread not in WAIT is ignored.
  - wait_set is ignored while stall is high.
  - wait_done is honoured during stall.
- Eligible threads: state READY and not being parked this cycle.
- Selection uses rotating priority starting at (last_issued+1) mod NUM_THREADS. The highest-priority eligible thread is issued.
- If no thread is eligible, a bubble (0) is issued and last_issued is unchanged.
- A single READY thread issues every cycle.
- Delay line: sel_pipe[0] = thread_sel_IF. sel_pipe[k] <= sel_pipe[k-1] on each non-stall edge.
- Stall high: sel_pipe, last_issued and issue_cnt all hold.

## Timing
- Reset values:
  - All selects 0; issue_valid 0.
  - All threads OFF; thread_state 0.
  - last_issued = NUM_THREADS-1, so thread 0 has first priority.
  - issue_cnt 0.
- thread_en sampled high at edge k: thread is READY after edge k and can appear in thread_sel_IF after edge k+1.
- A thread appears on thread_sel_ID 1 edge after IF and on thread_sel_WB PIPE_DEPTH-1 edges after IF, with non-stall edges only counted.
- A parked thread is not issued on the same edge as its wait_set.
- wait_done at edge k: thread is READY after edge k and eligible for issue at edge k+1.
- thread_en dropping mid-pipe: no new issues for that thread. Entries already in the delay line drain unchanged.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Deassertion is synchronised by the integrator.

## Configuration
- THREAD_SCHED_PERF_EN defined:
  - issue_cnt[i] increments on every non-stall edge that issues thread i.
  - Counters wrap modulo 2^CNT_WIDTH.
- THREAD_SCHED_PERF_EN undefined:
  - No counter logic is built.
  - The issue_cnt port remains and is tied to 0.

## Structure
- Package thread_sched_pkg holds:
  - the state typedef and encodings OFF, READY and WAIT;
  - localparam for the minimum PIPE_DEPTH (3).
- Sub-module rr_arbiter: parameterised one-hot rotating-priority arbiter.
  - Inputs: request vector, last-grant vector.
  - Output: one-hot grant, or 0 when there are no requests.
- Top level contains the per-thread state registers, the delay line and the optional counters.

## Test plan
- Single thread: reset, then thread_en=4'b0101 held → thread_sel_IF settles to the sequence 0001, 0100, 0001, 0100…; thread_sel_WB repeats it 4 edges later (PIPE_DEPTH=5).
- Park and wake:
  - All threads enabled.
  - wait_set with wait_thread=0010 while thread 1 is in ID → 0010 is absent from the issue stream.
  - wait_done=0010 pulse → 0010 is reissued within 4 edges.
- Stall: 3-cycle stall mid-stream → all selects and issue_cnt hold for exactly 3 cycles; issue resumes at the next thread in rotation.
- All threads WAIT → thread_sel_IF=0 and issue_valid=0 on every edge until the first wait_done.
- Disable during WAIT: thread_en bit cleared while in WAIT, then wait_done → thread_state reads OFF and the thread is never issued.
- Asynchronous reset mid-operation, with THREAD_SCHED_PERF_EN defined: after 100 issues all counts are non-zero; asserting reset clears outputs, issue_cnt and thread_state within the same cycle.
